// File: rtl/multi_channel_pulse_width_detector.sv
// N_CH-channel edge detector with per-channel pulse-width measurement and
// short / in-window / long classification, plus a saturating in-window event count.
module multi_channel_pulse_width_detector #(
    parameter int N_CH     = 4,
    parameter int MAX_W    = 8,
    parameter int CW       = $clog2(MAX_W + 2),
    parameter bit POLARITY = 1'b0,
    parameter int EVW      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    a,
    input  logic [N_CH-1:0]    en,
    input  logic [CW-1:0]      cfg_min,
    input  logic [CW-1:0]      cfg_max,
    input  logic               ev_clr,
    output logic [N_CH-1:0]    rise_det,
    output logic [N_CH-1:0]    fall_det,
    output logic [N_CH-1:0]    pulse_det,
    output logic [N_CH-1:0]    short_det,
    output logic [N_CH-1:0]    long_det,
    output logic [N_CH*CW-1:0] pulse_len,
    output logic [EVW-1:0]     ev_count
);

    localparam logic [CW-1:0] SAT     = CW'(MAX_W + 1);
    localparam logic [CW-1:0] MAX_LIM = CW'(MAX_W);
    localparam int            PCW     = $clog2(N_CH + 1);
    localparam int            SW      = EVW + PCW;
    localparam logic [SW-1:0] EV_MAX  = SW'({EVW{1'b1}});

    logic [N_CH-1:0] a_r_q, a_r_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [EVW-1:0]  ev_count_q, ev_count_d;

    logic [CW-1:0]   min_e, max_e;
    logic            act, run_end, sat, below_min;
    logic [PCW-1:0]  pulse_pop;
    logic [SW-1:0]   ev_sum;

    always_comb begin
        min_e     = (cfg_min == '0) ? CW'(1) : cfg_min;
        max_e     = (cfg_max > MAX_LIM) ? MAX_LIM : cfg_max;
        a_r_d     = a;
        cnt_d     = '{default: '0};
        rise_det  = '0;
        fall_det  = '0;
        pulse_det = '0;
        short_det = '0;
        long_det  = '0;
        pulse_len = '0;
        act       = 1'b0;
        run_end   = 1'b0;
        sat       = 1'b0;
        below_min = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            act = a[i] ^ POLARITY;
            if (en[i] && act)
                cnt_d[i] = (cnt_q[i] == SAT) ? SAT : cnt_q[i] + CW'(1);
            else
                cnt_d[i] = '0;

            run_end   = rst & en[i] & ~act & (cnt_q[i] != '0);
            sat       = (cnt_q[i] == SAT);
            below_min = (cnt_q[i] < min_e);

            // Saturation outranks a too-large cfg_min; below-min outranks
            // above-max when the window is inverted, so exactly one flag fires.
            short_det[i] = run_end & ~sat & below_min;
            long_det[i]  = run_end & (sat | (~below_min & (cnt_q[i] > max_e)));
            pulse_det[i] = run_end & ~sat & ~below_min & (cnt_q[i] <= max_e);
            if (run_end)
                pulse_len[i*CW +: CW] = cnt_q[i];

            rise_det[i] = rst & en[i] & a[i] & ~a_r_q[i];
            fall_det[i] = rst & en[i] & ~a[i] & a_r_q[i];
        end
    end

    always_comb begin
        pulse_pop = '0;
        for (int unsigned i = 0; i < N_CH; i++)
            pulse_pop = pulse_pop + PCW'(pulse_det[i]);
        ev_sum = SW'(ev_count_q) + SW'(pulse_pop);
        if (ev_clr)
            ev_count_d = '0;
        else if (ev_sum > EV_MAX)
            ev_count_d = '1;
        else
            ev_count_d = ev_sum[EVW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r_q      <= '0;
            ev_count_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++)
                cnt_q[i] <= '0;
        end else begin
            a_r_q      <= a_r_d;
            ev_count_q <= ev_count_d;
            for (int unsigned i = 0; i < N_CH; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    assign ev_count = ev_count_q;

endmodule

// File: tb/tb_multi_channel_pulse_width_detector.sv
// Bench for multi_channel_pulse_width_detector: three instances (active-high,
// active-low, 2-bit event counter) share stimulus and are compared to a history-based model.
module tb_multi_channel_pulse_width_detector;

    localparam int SAT = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] a, en, cfg_min, cfg_max;
    logic       ev_clr;

    logic [3:0]  rise_o [3];
    logic [3:0]  fall_o [3];
    logic [3:0]  pulse_o[3];
    logic [3:0]  short_o[3];
    logic [3:0]  long_o [3];
    logic [15:0] len_o  [3];
    logic [15:0] ev0, ev1;
    logic [1:0]  ev2;

    int checks = 0;
    int passes = 0;

    multi_channel_pulse_width_detector #(.N_CH(4), .MAX_W(8), .POLARITY(1'b0), .EVW(16)) u0 (
        .clk(clk), .rst(rst), .a(a), .en(en), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .ev_clr(ev_clr), .rise_det(rise_o[0]), .fall_det(fall_o[0]), .pulse_det(pulse_o[0]),
        .short_det(short_o[0]), .long_det(long_o[0]), .pulse_len(len_o[0]), .ev_count(ev0));

    multi_channel_pulse_width_detector #(.N_CH(4), .MAX_W(8), .POLARITY(1'b1), .EVW(16)) u1 (
        .clk(clk), .rst(rst), .a(a), .en(en), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .ev_clr(ev_clr), .rise_det(rise_o[1]), .fall_det(fall_o[1]), .pulse_det(pulse_o[1]),
        .short_det(short_o[1]), .long_det(long_o[1]), .pulse_len(len_o[1]), .ev_count(ev1));

    multi_channel_pulse_width_detector #(.N_CH(4), .MAX_W(8), .POLARITY(1'b0), .EVW(2)) u2 (
        .clk(clk), .rst(rst), .a(a), .en(en), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .ev_clr(ev_clr), .rise_det(rise_o[2]), .fall_det(fall_o[2]), .pulse_det(pulse_o[2]),
        .short_det(short_o[2]), .long_det(long_o[2]), .pulse_len(len_o[2]), .ev_count(ev2));

    // Reference model: per instance/channel, a shift history of "enabled and active"
    // samples; the width of a run is the number of trailing ones.
    bit          pol   [3] = '{1'b0, 1'b1, 1'b0};
    int          evmax [3] = '{65535, 65535, 3};
    logic [15:0] hist  [3][4];
    logic [3:0]  prev_a;
    int          ev_m  [3];
    logic [3:0]  e_rise[3], e_fall[3], e_pulse[3], e_short[3], e_long[3];
    logic [15:0] e_len [3];

    function automatic int trail_ones(logic [15:0] h);
        int n = 0;
        while (n < 16 && h[n]) n++;
        return n;
    endfunction

    function automatic int ev_of(int k);
        if (k == 0) return int'(ev0);
        if (k == 1) return int'(ev1);
        return int'(ev2);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            ev_m[k] = 0;
            for (int c = 0; c < 4; c++) hist[k][c] = '0;
        end
        prev_a = '0;
    endtask

    task automatic model_eval();
        int min_e, max_e, run, w;
        bit act;
        min_e = (cfg_min == 0) ? 1 : int'(cfg_min);
        max_e = (cfg_max > 8) ? 8 : int'(cfg_max);
        for (int k = 0; k < 3; k++) begin
            e_rise[k] = '0; e_fall[k] = '0; e_pulse[k] = '0;
            e_short[k] = '0; e_long[k] = '0; e_len[k] = '0;
            if (rst === 1'b1) begin
                for (int c = 0; c < 4; c++) begin
                    run = trail_ones(hist[k][c]);
                    w   = (run > SAT) ? SAT : run;
                    act = a[c] ^ pol[k];
                    e_rise[k][c] = en[c] & a[c] & ~prev_a[c];
                    e_fall[k][c] = en[c] & ~a[c] & prev_a[c];
                    if (en[c] && !act && run > 0) begin
                        e_len[k][c*4 +: 4] = 4'(w);
                        if (run >= SAT)      e_long[k][c]  = 1'b1;
                        else if (w < min_e)  e_short[k][c] = 1'b1;
                        else if (w > max_e)  e_long[k][c]  = 1'b1;
                        else                 e_pulse[k][c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_update();
        int pc;
        model_eval();
        if (rst !== 1'b1) begin
            model_clear();
        end else begin
            for (int k = 0; k < 3; k++) begin
                pc = $countones(e_pulse[k]);
                if (ev_clr) ev_m[k] = 0;
                else ev_m[k] = (ev_m[k] + pc > evmax[k]) ? evmax[k] : ev_m[k] + pc;
                for (int c = 0; c < 4; c++)
                    hist[k][c] = {hist[k][c][14:0], en[c] & (a[c] ^ pol[k])};
            end
            prev_a = a;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic assert_rst();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        assert_rst();
        a = 4'hF; en = 4'hF; cfg_min = 4'd1; cfg_max = 4'd1;
        settle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rise_o[k], fall_o[k], pulse_o[k], short_o[k], long_o[k], len_o[k]} !== 36'h0)
                $display("FAIL reset_outputs[%0d]: got %h required 0", k,
                         {rise_o[k], fall_o[k], pulse_o[k], short_o[k], long_o[k], len_o[k]});
            else passes++;
        end
        clk_step();
        checks++;
        if (ev0 !== 16'd0) $display("FAIL reset_ev_count: got %0d required 0", ev0);
        else passes++;
        rst = 1'b1;
        settle();
        checks++;
        if (rise_o[0] !== 4'hF) $display("FAIL first_cycle_rise: got %h required f", rise_o[0]);
        else passes++;
        clk_step();
        a = 4'h0;
        settle();
        checks++;
        if (pulse_o[0] !== 4'hF || fall_o[0] !== 4'hF)
            $display("FAIL first_cycle_pulse: got pulse %h fall %h required f f", pulse_o[0], fall_o[0]);
        else passes++;
        clk_step();
    endtask

    task automatic test_legacy();
        logic [15:0] pat, er, ep;
        pat = 16'b1001011011110001;
        er  = 16'b1001010010000001;
        ep  = 16'b0100100000000000;
        assert_rst();
        a = 4'h0; en = 4'h1; cfg_min = 4'd1; cfg_max = 4'd1;
        clk_step();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a[0] = pat[15-i];
            settle();
            checks++;
            if (rise_o[0][0] !== er[15-i])
                $display("FAIL legacy_rise cycle %0d: got %b required %b", i, rise_o[0][0], er[15-i]);
            else passes++;
            checks++;
            if (pulse_o[0][0] !== ep[15-i])
                $display("FAIL legacy_pulse cycle %0d: got %b required %b", i, pulse_o[0][0], ep[15-i]);
            else passes++;
            clk_step();
        end
    endtask

    task automatic test_window();
        bit xs[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        bit xp[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bit xl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        a = 4'h0; en = 4'hF; cfg_min = 4'd2; cfg_max = 4'd3;
        clk_step(); clk_step();
        ev_clr = 1'b1; clk_step(); ev_clr = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c <= p; c++) begin
                a[1] = 1'b1;
                clk_step();
            end
            a[1] = 1'b0;
            settle();
            checks++;
            if ({short_o[0][1], pulse_o[0][1], long_o[0][1]} !== {xs[p], xp[p], xl[p]} ||
                len_o[0][7:4] !== 4'(p + 1))
                $display("FAIL window_width%0d: got s/p/l %b%b%b len %0d required %b%b%b len %0d",
                         p + 1, short_o[0][1], pulse_o[0][1], long_o[0][1], len_o[0][7:4],
                         xs[p], xp[p], xl[p], p + 1);
            else passes++;
            clk_step(); clk_step();
        end
        settle();
        checks++;
        if (ev0 !== 16'd2) $display("FAIL window_ev_count: got %0d required 2", ev0);
        else passes++;
        checks++;
        if (ev2 !== 2'd2) $display("FAIL window_ev_count_evw2: got %0d required 2", ev2);
        else passes++;
    endtask

    task automatic test_saturation();
        a = 4'h0; en = 4'hF; cfg_min = 4'd1; cfg_max = 4'd15;
        clk_step();
        for (int c = 0; c < 8; c++) begin
            a[0] = 1'b1;
            clk_step();
        end
        a[0] = 1'b0;
        settle();
        checks++;
        if (pulse_o[0][0] !== 1'b1 || len_o[0][3:0] !== 4'd8)
            $display("FAIL sat_width8: got pulse %b len %0d required 1 len 8", pulse_o[0][0], len_o[0][3:0]);
        else passes++;
        clk_step();
        for (int c = 0; c < 12; c++) begin
            a[0] = 1'b1;
            settle();
            if (c >= 9) begin
                checks++;
                if (u0.cnt_q[0] !== 4'd9)
                    $display("FAIL sat_cnt_hold cycle %0d: got %0d required 9", c, u0.cnt_q[0]);
                else passes++;
            end
            clk_step();
        end
        a[0] = 1'b0;
        settle();
        checks++;
        if (long_o[0][0] !== 1'b1 || pulse_o[0][0] !== 1'b0 || len_o[0][3:0] !== 4'd9)
            $display("FAIL sat_end: got long %b pulse %b len %0d required 1 0 9",
                     long_o[0][0], pulse_o[0][0], len_o[0][3:0]);
        else passes++;
        clk_step();
    endtask

    task automatic test_polarity();
        a = 4'hF; en = 4'hF; cfg_min = 4'd1; cfg_max = 4'd2;
        clk_step(); clk_step(); clk_step();
        a[0] = 1'b0;
        settle();
        checks++;
        if (fall_o[1][0] !== 1'b1) $display("FAIL pol1_fall: got %b required 1", fall_o[1][0]);
        else passes++;
        clk_step(); clk_step();
        a[0] = 1'b1;
        settle();
        checks++;
        if (pulse_o[1][0] !== 1'b1 || len_o[1][3:0] !== 4'd2 || rise_o[1][0] !== 1'b1 ||
            short_o[1][0] !== 1'b0 || long_o[1][0] !== 1'b0)
            $display("FAIL pol1_pulse: got p%b len %0d rise %b s%b l%b required p1 len 2 rise 1 s0 l0",
                     pulse_o[1][0], len_o[1][3:0], rise_o[1][0], short_o[1][0], long_o[1][0]);
        else passes++;
        clk_step();
    endtask

    task automatic test_en_reset();
        a = 4'h0; en = 4'hF; cfg_min = 4'd1; cfg_max = 4'd2;
        clk_step();
        a[2] = 1'b1;
        clk_step(); clk_step(); clk_step();
        en[2] = 1'b0;
        clk_step();
        a[2] = 1'b0;
        settle();
        checks++;
        if ({pulse_o[0][2], short_o[0][2], long_o[0][2], fall_o[0][2]} !== 4'b0 || len_o[0][11:8] !== 4'd0)
            $display("FAIL en_drop: got p%b s%b l%b f%b len %0d required all 0",
                     pulse_o[0][2], short_o[0][2], long_o[0][2], fall_o[0][2], len_o[0][11:8]);
        else passes++;
        clk_step();
        en[2] = 1'b1;
        clk_step();
        a[2] = 1'b1;
        clk_step(); clk_step();
        en[2] = 1'b0;
        clk_step();
        en[2] = 1'b1;
        clk_step(); clk_step();
        a[2] = 1'b0;
        settle();
        checks++;
        if (pulse_o[0][2] !== 1'b1 || len_o[0][11:8] !== 4'd2)
            $display("FAIL en_reassert: got pulse %b len %0d required 1 len 2", pulse_o[0][2], len_o[0][11:8]);
        else passes++;
        clk_step();
        a[3] = 1'b1;
        clk_step(); clk_step(); clk_step();
        a[3] = 1'b0;
        assert_rst();
        settle();
        checks++;
        if ({rise_o[0], fall_o[0], pulse_o[0], short_o[0], long_o[0], len_o[0]} !== 36'h0)
            $display("FAIL rst_midrun: got %h required 0",
                     {rise_o[0], fall_o[0], pulse_o[0], short_o[0], long_o[0], len_o[0]});
        else passes++;
        clk_step();
        rst = 1'b1;
        settle();
        checks++;
        if ({pulse_o[0][3], short_o[0][3], long_o[0][3], fall_o[0][3]} !== 4'b0)
            $display("FAIL rst_release: got p%b s%b l%b f%b required all 0",
                     pulse_o[0][3], short_o[0][3], long_o[0][3], fall_o[0][3]);
        else passes++;
        clk_step();
    endtask

    task automatic test_simultaneous();
        a = 4'h0; en = 4'hF; cfg_min = 4'd1; cfg_max = 4'd2;
        clk_step();
        ev_clr = 1'b1; clk_step(); ev_clr = 1'b0;
        for (int p = 0; p < 2; p++) begin
            a[0] = 1'b1; clk_step();
            a[0] = 1'b0; clk_step();
        end
        settle();
        checks++;
        if (ev2 !== 2'd2) $display("FAIL simul_pre_ev: got %0d required 2", ev2);
        else passes++;
        a = 4'hF; clk_step(); clk_step();
        a = 4'h0;
        settle();
        checks++;
        if (pulse_o[2] !== 4'hF || len_o[2] !== 16'h2222)
            $display("FAIL simul_pulse: got %h len %h required f len 2222", pulse_o[2], len_o[2]);
        else passes++;
        clk_step();
        settle();
        checks++;
        if (ev2 !== 2'd3) $display("FAIL simul_ev_sat: got %0d required 3", ev2);
        else passes++;
        checks++;
        if (ev0 !== 16'd6) $display("FAIL simul_ev16: got %0d required 6", ev0);
        else passes++;
        a = 4'hF; clk_step(); clk_step();
        a = 4'h0; ev_clr = 1'b1;
        settle();
        checks++;
        if (pulse_o[0] !== 4'hF) $display("FAIL simul_clr_pulse: got %h required f", pulse_o[0]);
        else passes++;
        clk_step();
        ev_clr = 1'b0;
        settle();
        checks++;
        if (ev2 !== 2'd0 || ev0 !== 16'd0)
            $display("FAIL simul_ev_clr: got %0d/%0d required 0/0", ev2, ev0);
        else passes++;
    endtask

    task automatic test_random();
        int slow;
        for (int n = 0; n < 600; n++) begin
            slow = ((n / 100) % 2 == 1) ? 12 : 3;
            if (rst !== 1'b1) rst = 1'b1;
            else if ($urandom_range(0, 149) == 0) assert_rst();
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, slow) == 0) a[c] = ~a[c];
                en[c] = ($urandom_range(0, 24) != 0);
            end
            if (n % 25 == 0) begin
                cfg_min = 4'($urandom_range(0, 15));
                cfg_max = 4'($urandom_range(0, 15));
            end
            ev_clr = ($urandom_range(0, 59) == 0);
            settle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({rise_o[k], fall_o[k]} !== {e_rise[k], e_fall[k]})
                    $display("FAIL rand_edges[%0d] cyc %0d: got %h required %h", k, n,
                             {rise_o[k], fall_o[k]}, {e_rise[k], e_fall[k]});
                else passes++;
                checks++;
                if ({pulse_o[k], short_o[k], long_o[k], len_o[k]} !== {e_pulse[k], e_short[k], e_long[k], e_len[k]})
                    $display("FAIL rand_class[%0d] cyc %0d: got %h required %h", k, n,
                             {pulse_o[k], short_o[k], long_o[k], len_o[k]},
                             {e_pulse[k], e_short[k], e_long[k], e_len[k]});
                else passes++;
                checks++;
                if (ev_of(k) !== ev_m[k])
                    $display("FAIL rand_ev[%0d] cyc %0d: got %0d required %0d", k, n, ev_of(k), ev_m[k]);
                else passes++;
            end
            clk_step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; a = '0; en = '0; cfg_min = 4'd1; cfg_max = 4'd1; ev_clr = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_legacy();
        test_window();
        test_saturation();
        test_polarity();
        test_en_reset();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
